// File: rtl/sfp_cycle_scheduler.sv
// SFP master exchange scheduler: periodic Tx start, Rx timeout with bounded retry, link fault and overrun tracking.
// Optional macro SFP_SCHED_LATENCY_EN adds o_last_latency (START-to-DONE cycle count of the last exchange).
module sfp_cycle_scheduler #(
  parameter int C_PERIOD_CNT  = 20000,
  parameter int C_TIMEOUT_CNT = 2000,
  parameter int C_MAX_RETRY   = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sfp_m_en,
  input  logic        i_aurora_rx_end_flag,
  input  logic        i_fault_clr,
  output logic        o_aurora_tx_start_flag,
  output logic        o_axi_data_valid,
  output logic        o_link_fault,
  output logic        o_overrun,
  output logic [31:0] o_cycle_cnt,
  output logic [15:0] o_timeout_cnt,
  output logic [2:0]  o_state
`ifdef SFP_SCHED_LATENCY_EN
  ,
  output logic [15:0] o_last_latency
`endif
);

  localparam int PW = $clog2(C_PERIOD_CNT);
  localparam int TW = $clog2(C_TIMEOUT_CNT);
  localparam int RW = $clog2(C_MAX_RETRY + 2);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    START     = 3'd2,
    WAIT_RX   = 3'd3,
    DONE      = 3'd4,
    FAULT     = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] period_cnt;
  logic [TW-1:0] to_cnt;
  logic [RW-1:0] retry_cnt;
  logic          rx_q;
  logic          tick;
  logic          rx_edge;
  logic          timeout;
  logic          busy;
  logic          retry_ok;

  assign tick     = i_sfp_m_en && (period_cnt == PW'(C_PERIOD_CNT - 1));
  assign rx_edge  = i_aurora_rx_end_flag && !rx_q;
  // An rx edge on the timeout cycle wins, so the timeout is suppressed outright.
  assign timeout  = i_sfp_m_en && (state == WAIT_RX) &&
                    (to_cnt == TW'(C_TIMEOUT_CNT - 1)) && !rx_edge;
  assign busy     = (state == START) || (state == WAIT_RX) ||
                    (state == DONE) || (state == FAULT);
  assign retry_ok = retry_cnt < RW'(C_MAX_RETRY);

  assign o_aurora_tx_start_flag = i_sfp_m_en && (state == START);
  assign o_axi_data_valid       = i_sfp_m_en && (state == DONE);
  assign o_link_fault           = (state == FAULT);
  assign o_state                = state;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!i_sfp_m_en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:      state_nxt = WAIT_TICK;
        WAIT_TICK: if (tick) state_nxt = START;
        START:     state_nxt = WAIT_RX;
        WAIT_RX: begin
          if (rx_edge)      state_nxt = DONE;
          else if (timeout) state_nxt = retry_ok ? START : FAULT;
        end
        DONE:      state_nxt = WAIT_TICK;
        FAULT:     if (i_fault_clr) state_nxt = WAIT_TICK;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      period_cnt    <= '0;
      to_cnt        <= '0;
      retry_cnt     <= '0;
      rx_q          <= 1'b0;
      o_overrun     <= 1'b0;
      o_cycle_cnt   <= '0;
      o_timeout_cnt <= '0;
    end else begin
      rx_q <= i_aurora_rx_end_flag;

      if (!i_sfp_m_en || tick) period_cnt <= '0;
      else                     period_cnt <= period_cnt + 1'b1;

      if (!i_sfp_m_en || state == START) to_cnt <= '0;
      else if (state == WAIT_RX)         to_cnt <= to_cnt + 1'b1;

      if (!i_sfp_m_en || (state == WAIT_TICK && tick)) retry_cnt <= '0;
      else if (timeout && retry_ok)                    retry_cnt <= retry_cnt + 1'b1;

      if (i_fault_clr)       o_overrun <= 1'b0;
      else if (tick && busy) o_overrun <= 1'b1;

      if (i_sfp_m_en && state == DONE) o_cycle_cnt <= o_cycle_cnt + 1'b1;

      if (timeout && o_timeout_cnt != 16'hFFFF) o_timeout_cnt <= o_timeout_cnt + 1'b1;
    end
  end

`ifdef SFP_SCHED_LATENCY_EN
  logic [15:0] lat_cnt;

  // START counts as the first cycle, so DONE sees the full START-to-DONE span.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      lat_cnt        <= '0;
      o_last_latency <= '0;
    end else begin
      if (i_sfp_m_en && state == START)                lat_cnt <= 16'd1;
      else if (state == WAIT_RX && lat_cnt != 16'hFFFF) lat_cnt <= lat_cnt + 1'b1;

      if (i_sfp_m_en && state == DONE) o_last_latency <= lat_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_sfp_cycle_scheduler.sv
// Directed self-checking bench for sfp_cycle_scheduler (period 100, timeout 20, two retries).
module tb_sfp_cycle_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sfp_m_en = 1'b0;
  logic        rx_end = 1'b0;
  logic        fault_clr = 1'b0;
  logic        tx_start;
  logic        data_valid;
  logic        link_fault;
  logic        overrun;
  logic [31:0] cycle_cnt;
  logic [15:0] timeout_cnt;
  logic [2:0]  state;
`ifdef SFP_SCHED_LATENCY_EN
  logic [15:0] last_latency;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  sfp_cycle_scheduler #(
    .C_PERIOD_CNT(100),
    .C_TIMEOUT_CNT(20),
    .C_MAX_RETRY(2)
  ) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .i_sfp_m_en(sfp_m_en),
    .i_aurora_rx_end_flag(rx_end),
    .i_fault_clr(fault_clr),
    .o_aurora_tx_start_flag(tx_start),
    .o_axi_data_valid(data_valid),
    .o_link_fault(link_fault),
    .o_overrun(overrun),
    .o_cycle_cnt(cycle_cnt),
    .o_timeout_cnt(timeout_cnt),
    .o_state(state)
`ifdef SFP_SCHED_LATENCY_EN
    ,
    .o_last_latency(last_latency)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_start(input int budget, output int at, output bit found);
    found = 1'b0;
    at = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_start) begin
        found = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_start, data_valid, link_fault, overrun} !== 4'b0 || state !== 3'd0 ||
        cycle_cnt !== 32'd0 || timeout_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: state=%0d cycle=%0d timeouts=%0d flags=%b, required all 0",
               state, cycle_cnt, timeout_cnt, {tx_start, data_valid, link_fault, overrun});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("[TB] FAIL idle_after_release: state=%0d, required 0", state);
    end
  endtask

  task automatic test_nominal();
    int s_prev, s_cur;
    bit found;
    @(posedge clk);
    #1 sfp_m_en = 1'b1;
    s_prev = 0;
    for (int n = 0; n < 5; n++) begin
      wait_start(150, s_cur, found);
      checks++;
      if (!found) begin
        errors++;
        $display("[TB] FAIL nominal_start%0d: no start pulse within 150 cycles", n);
        return;
      end
      if (n > 0) begin
        checks++;
        if (s_cur - s_prev !== 100) begin
          errors++;
          $display("[TB] FAIL nominal_period%0d: got %0d cycles, required 100", n, s_cur - s_prev);
        end
      end
      s_prev = s_cur;
      for (int k = 1; k <= 10; k++) begin
        @(posedge clk);
        #1;
        if (k == 10) rx_end = 1'b1;
        @(negedge clk);
        if (k == 1) begin
          checks++;
          if (tx_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_width%0d: tx_start=%b one cycle after start, required 0", n, tx_start);
          end
        end
      end
      checks++;
      if (data_valid !== 1'b0 || state !== 3'd3) begin
        errors++;
        $display("[TB] FAIL nominal_rx_cycle%0d: valid=%b state=%0d, required 0/3", n, data_valid, state);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (data_valid !== 1'b1 || state !== 3'd4) begin
        errors++;
        $display("[TB] FAIL nominal_done%0d: valid=%b state=%0d, required 1/4", n, data_valid, state);
      end
      @(posedge clk);
      #1 rx_end = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (cycle_cnt !== 32'd5 || timeout_cnt !== 16'd0 || state !== 3'd1) begin
      errors++;
      $display("[TB] FAIL nominal_counts: cycle=%0d timeouts=%0d state=%0d, required 5/0/1",
               cycle_cnt, timeout_cnt, state);
    end
`ifdef SFP_SCHED_LATENCY_EN
    checks++;
    if (last_latency !== 16'd11) begin
      errors++;
      $display("[TB] FAIL latency: got %0d, required 11", last_latency);
    end
`endif
  endtask

  task automatic test_retry_and_overrun();
    int s0, s1, s2;
    bit found;
    bit saw_start;
    wait_start(150, s0, found);
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL retry_start0: no start pulse within 150 cycles");
      return;
    end
    wait_start(40, s1, found);
    checks++;
    if (!found || s1 - s0 !== 21) begin
      errors++;
      $display("[TB] FAIL retry_gap1: found=%b gap=%0d, required 21", found, s1 - s0);
    end
    wait_start(40, s2, found);
    checks++;
    if (!found || s2 - s1 !== 21) begin
      errors++;
      $display("[TB] FAIL retry_gap2: found=%b gap=%0d, required 21", found, s2 - s1);
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++;
    if (state !== 3'd3 || timeout_cnt !== 16'd2) begin
      errors++;
      $display("[TB] FAIL retry_last_wait: state=%0d timeouts=%0d, required 3/2", state, timeout_cnt);
    end
    @(negedge clk);
    checks++;
    if (state !== 3'd5 || link_fault !== 1'b1 || timeout_cnt !== 16'd3 || overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fault_entry: state=%0d fault=%b timeouts=%0d overrun=%b, required 5/1/3/0",
               state, link_fault, timeout_cnt, overrun);
    end
    // A tick lands ~36 cycles into FAULT; it must set overrun and start nothing.
    saw_start = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (tx_start) saw_start = 1'b1;
    end
    checks++;
    if (saw_start !== 1'b0 || overrun !== 1'b1 || state !== 3'd5) begin
      errors++;
      $display("[TB] FAIL overrun: start_seen=%b overrun=%b state=%0d, required 0/1/5",
               saw_start, overrun, state);
    end
    @(posedge clk);
    #1 fault_clr = 1'b1;
    @(posedge clk);
    #1 fault_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 3'd1 || link_fault !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fault_clear: state=%0d fault=%b overrun=%b, required 1/0/0",
               state, link_fault, overrun);
    end
  endtask

  task automatic test_race();
    int s3;
    bit found;
    wait_start(150, s3, found);
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL race_start: no start pulse within 150 cycles");
      return;
    end
    repeat (20) @(posedge clk);
    #1 rx_end = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 3'd3) begin
      errors++;
      $display("[TB] FAIL race_wait: state=%0d, required 3", state);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (state !== 3'd4 || data_valid !== 1'b1 || timeout_cnt !== 16'd3) begin
      errors++;
      $display("[TB] FAIL race_done: state=%0d valid=%b timeouts=%0d, required 4/1/3",
               state, data_valid, timeout_cnt);
    end
    @(posedge clk);
    #1 rx_end = 1'b0;
    @(negedge clk);
    checks++;
    if (cycle_cnt !== 32'd6 || timeout_cnt !== 16'd3 || state !== 3'd1) begin
      errors++;
      $display("[TB] FAIL race_after: cycle=%0d timeouts=%0d state=%0d, required 6/3/1",
               cycle_cnt, timeout_cnt, state);
    end
  endtask

  task automatic test_disable();
    int s4;
    bit found;
    bit saw_valid;
    wait_start(150, s4, found);
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL disable_start: no start pulse within 150 cycles");
      return;
    end
    repeat (5) @(posedge clk);
    #1 sfp_m_en = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rx_end = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || data_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL disable_idle: state=%0d valid=%b, required 0/0", state, data_valid);
    end
    saw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (data_valid) saw_valid = 1'b1;
    end
    rx_end = 1'b0;
    checks++;
    if (saw_valid !== 1'b0 || cycle_cnt !== 32'd6 || timeout_cnt !== 16'd3) begin
      errors++;
      $display("[TB] FAIL disable_retain: valid_seen=%b cycle=%0d timeouts=%0d, required 0/6/3",
               saw_valid, cycle_cnt, timeout_cnt);
    end
  endtask

  task automatic test_async_reset();
    int s5;
    bit found;
    @(posedge clk);
    #1 sfp_m_en = 1'b1;
    wait_start(150, s5, found);
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL reenable_start: no start pulse within 150 cycles");
      return;
    end
    @(negedge clk);
    checks++;
    if (state !== 3'd3 || cycle_cnt !== 32'd6) begin
      errors++;
      $display("[TB] FAIL prereset_wait: state=%0d cycle=%0d, required 3/6", state, cycle_cnt);
    end
    // Reset lands mid-cycle, well away from any clock edge.
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_start, data_valid, link_fault, overrun} !== 4'b0 || state !== 3'd0 ||
        cycle_cnt !== 32'd0 || timeout_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: state=%0d cycle=%0d timeouts=%0d flags=%b, required all 0",
               state, cycle_cnt, timeout_cnt, {tx_start, data_valid, link_fault, overrun});
    end
    sfp_m_en = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_retry_and_overrun();
    test_race();
    test_disable();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
